// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the pipeline stages.
//   - RESET_PC / NOP_INST : default PC after reset and the bubble instruction
//   - if_state_t          : IF stage FSM encoding (IF_FETCH, IF_HOLD)
//   - STALL_PC / STALL_IF : bit positions in the 6-bit stall vector
//   - word_align()        : clears the byte offset of an address
// -----------------------------------------------------------------------------
package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int STALL_W  = 6;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_byte_asm.sv
// -----------------------------------------------------------------------------
// if_byte_asm
//   Collects the four bytes of one instruction word. Tracks which byte of the
//   word is being fetched and presents the assembled word combinationally, so
//   the word is complete in the same cycle the last byte is accepted.
//
//   Ports
//     clk       in   1   clock
//     rst       in   1   synchronous reset, active-high
//     clear     in   1   restart at byte 0 (redirect), wins over accept
//     accept    in   1   rdata is a wanted byte; store it and advance
//     rdata     in   8   byte returned by memory
//     byte_idx  out  2   index of the byte currently being fetched
//     word      out  32  assembled word (byte 3 taken straight from rdata)
// -----------------------------------------------------------------------------
module if_byte_asm #(
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  rdata,
    output logic [1:0]  byte_idx,
    output logic [31:0] word
);

    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] byte2;

    // Index wraps 3 -> 0 on its own when the last byte is accepted.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= 2'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // NOTE: byte buffers carry no reset; each is written before the word that reads it completes.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (byte_idx)
                2'd0:    byte0 <= rdata;
                2'd1:    byte1 <= rdata;
                2'd2:    byte2 <= rdata;
                default: ;
            endcase
        end
    end

    // Byte fetched from pc+0 goes to the low lane in little-endian mode and to
    // the high lane otherwise.
    assign word = LITTLE_ENDIAN ? {rdata, byte2, byte1, byte0}
                                : {byte0, byte1, byte2, rdata};

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage. Owns the PC and fetches each 32-bit instruction as
//   four byte reads over a req/ack port, then presents it to the IF/ID register
//   and waits in HOLD until the pipeline can take it. Branch redirects from ID
//   never abandon a byte transaction in flight: they are remembered and take
//   effect on the next ack (FETCH) or on the HOLD release.
//
//   Ports
//     clk              in   1   clock
//     rst              in   1   synchronous reset, active-high
//     stall            in   6   stall vector; stall[STALL_PC] holds in HOLD
//     branch_flag_i    in   1   taken branch/jump resolved in ID
//     branch_target_i  in   32  redirect target (bits [1:0] ignored)
//     mem_req_o        out  1   byte read request, held until ack
//     mem_addr_o       out  32  byte address
//     mem_ack_i        in   1   request accepted, rdata valid this cycle
//     mem_rdata_i      in   8   read byte
//     if_pc            out  32  PC of presented instruction
//     if_inst          out  32  presented instruction
//     stallreq_if      out  1   fetch in progress
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC      = cpu_defs::RESET_PC,
    parameter logic [31:0] NOP_INST      = cpu_defs::NOP_INST,
    parameter bit          LITTLE_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    import cpu_defs::*;

    if_state_t   state;
    if_state_t   state_next;

    logic        started;        // low for the cycle after reset: no request yet
    logic [31:0] pc;
    logic        redirect_pend;
    logic [31:0] redirect_tgt;
    logic [31:0] branch_tgt;

    logic [1:0]  byte_idx;
    logic [31:0] asm_word;

    logic        fetch_ack;
    logic        redirect_req;
    logic        word_done;
    logic        hold_release;

    // Only stall[STALL_PC] and the word-aligned target bits matter here.
    logic        unused_inputs;
    assign unused_inputs = ^{stall[STALL_W-1:1], branch_target_i[1:0]};

    assign branch_tgt   = word_align(branch_target_i);
    assign fetch_ack    = mem_req_o && mem_ack_i;
    assign redirect_req = branch_flag_i || redirect_pend;
    // A redirect arriving with the 4th ack drops the word (wrong path).
    assign word_done    = fetch_ack && !redirect_req && (byte_idx == 2'd3);
    assign hold_release = (state == IF_HOLD) && !stall[STALL_PC];

    if_byte_asm #(
        .LITTLE_ENDIAN (LITTLE_ENDIAN)
    ) u_byte_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (fetch_ack && redirect_req),
        .accept   (fetch_ack && !redirect_req),
        .rdata    (mem_rdata_i),
        .byte_idx (byte_idx),
        .word     (asm_word)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IF_FETCH: if (word_done)    state_next = IF_HOLD;
            IF_HOLD:  if (hold_release) state_next = IF_FETCH;
            default:                    state_next = IF_FETCH;
        endcase
    end

    always_comb begin
        mem_req_o   = (state == IF_FETCH) && started;
        stallreq_if = (state == IF_FETCH);
        mem_addr_o  = word_align(pc) + {30'd0, byte_idx};
    end

    // ------------------------------------------------------ PC / redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            started       <= 1'b0;
            pc            <= RESET_PC;
            redirect_pend <= 1'b0;
            redirect_tgt  <= RESET_PC;
        end else begin
            started <= 1'b1;
            case (state)
                IF_FETCH: begin
                    if (fetch_ack && redirect_req) begin
                        // The accepted byte is discarded; a same-cycle branch
                        // is newer than any pending target.
                        pc            <= branch_flag_i ? branch_tgt : redirect_tgt;
                        redirect_pend <= 1'b0;
                    end else if (branch_flag_i) begin
                        redirect_tgt  <= branch_tgt;
                        redirect_pend <= 1'b1;
                    end
                end
                IF_HOLD: begin
                    if (!stall[STALL_PC]) begin
                        if (branch_flag_i) begin
                            pc <= branch_tgt;
                        end else if (redirect_pend) begin
                            pc <= redirect_tgt;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                        redirect_pend <= 1'b0;
                    end else if (branch_flag_i) begin
                        redirect_tgt  <= branch_tgt;
                        redirect_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------- IF/ID presentation
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc   <= 32'h0000_0000;
            if_inst <= NOP_INST;
        end else if (word_done) begin
            if_pc   <= pc;
            if_inst <= asm_word;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
//   Directed bench for if_fetch. A little-endian instance runs the main
//   scenario from a vector table followed by hand-written sequences (PC wrap,
//   reset mid-fetch). A big-endian instance fetches one word and is held.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic clk;
    logic rst;

    // little-endian instance
    logic [5:0]  stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        ack_en;
    logic        req_le;
    logic [31:0] addr_le;
    logic        ack_le;
    logic [7:0]  rdata_le;
    logic [31:0] pc_le;
    logic [31:0] inst_le;
    logic        sreq_le;

    // big-endian instance
    logic [5:0]  stall_be;
    logic        branch_be;
    logic [31:0] target_be;
    logic        req_be;
    logic [31:0] addr_be;
    logic        ack_be;
    logic [7:0]  rdata_be;
    logic [31:0] pc_be;
    logic [31:0] inst_be;
    logic        sreq_be;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] W100  = 32'h5958_5B5A;   // bytes at 0x100..0x103 / 0x200..
    localparam logic [31:0] WWRAP = 32'hA5A4_A7A6;   // bytes at 0xFFFFFFFC..

    // Memory contents: a fixed instruction at 0..3, a simple pattern elsewhere.
    function automatic logic [7:0] mem_le(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1,
            32'd2,
            32'd3:   return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] mem_be(input logic [31:0] a);
        case (a)
            32'd3:   return 8'h13;
            32'd0,
            32'd1,
            32'd2:   return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Zero-wait memories: ack in the request cycle (gated by ack_en for LE).
    assign ack_le   = ack_en && req_le;
    assign rdata_le = ack_le ? mem_le(addr_le) : 8'h00;
    assign ack_be   = req_be;
    assign rdata_be = ack_be ? mem_be(addr_be) : 8'h00;

    if_fetch #(
        .RESET_PC      (32'h0000_0000),
        .NOP_INST      (32'h0000_0000),
        .LITTLE_ENDIAN (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .mem_req_o       (req_le),
        .mem_addr_o      (addr_le),
        .mem_ack_i       (ack_le),
        .mem_rdata_i     (rdata_le),
        .if_pc           (pc_le),
        .if_inst         (inst_le),
        .stallreq_if     (sreq_le)
    );

    if_fetch #(
        .RESET_PC      (32'h0000_0000),
        .NOP_INST      (32'h0000_0000),
        .LITTLE_ENDIAN (1'b0)
    ) dut_be (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall_be),
        .branch_flag_i   (branch_be),
        .branch_target_i (target_be),
        .mem_req_o       (req_be),
        .mem_addr_o      (addr_be),
        .mem_ack_i       (ack_be),
        .mem_rdata_i     (rdata_be),
        .if_pc           (pc_be),
        .if_inst         (inst_be),
        .stallreq_if     (sreq_be)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall0;
        logic        ack;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        sreq;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    function automatic vec_t mk(input logic s0, input logic a, input logic b,
                                input logic [31:0] t, input logic rq,
                                input logic [31:0] ad, input logic sr,
                                input logic [31:0] p, input logic [31:0] i);
        vec_t v;
        v.stall0 = s0; v.ack = a;   v.br = b;    v.tgt = t;
        v.req    = rq; v.addr = ad; v.sreq = sr; v.pc  = p; v.inst = i;
        return v;
    endfunction

    vec_t vecs [23];

    initial begin
        // Cycle-by-cycle script: inputs driven this cycle, outputs expected this cycle.
        //               stall ack br  target         req addr           sreq if_pc          if_inst
        vecs[0]  = mk(1'b0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h0);    // reset state, no req yet
        vecs[1]  = mk(1'b0, 1, 0, 32'h0,          1, 32'h0,          1, 32'h0,          32'h0);
        vecs[2]  = mk(1'b0, 1, 0, 32'h0,          1, 32'h1,          1, 32'h0,          32'h0);
        vecs[3]  = mk(1'b0, 1, 0, 32'h0,          1, 32'h2,          1, 32'h0,          32'h0);
        vecs[4]  = mk(1'b0, 1, 0, 32'h0,          1, 32'h3,          1, 32'h0,          32'h0);
        vecs[5]  = mk(1'b1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h13);   // HOLD, stalled
        vecs[6]  = mk(1'b1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h13);
        vecs[7]  = mk(1'b1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h13);
        vecs[8]  = mk(1'b0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h13);   // release
        vecs[9]  = mk(1'b0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h13);
        vecs[10] = mk(1'b0, 0, 1, 32'h100,        1, 32'h5,          1, 32'h0,          32'h13);   // branch, 2nd byte, no ack
        vecs[11] = mk(1'b0, 0, 0, 32'h0,          1, 32'h5,          1, 32'h0,          32'h13);
        vecs[12] = mk(1'b0, 1, 0, 32'h0,          1, 32'h5,          1, 32'h0,          32'h13);   // late ack, byte dropped
        vecs[13] = mk(1'b0, 1, 0, 32'h0,          1, 32'h100,        1, 32'h0,          32'h13);
        vecs[14] = mk(1'b0, 1, 0, 32'h0,          1, 32'h101,        1, 32'h0,          32'h13);
        vecs[15] = mk(1'b0, 1, 0, 32'h0,          1, 32'h102,        1, 32'h0,          32'h13);
        vecs[16] = mk(1'b0, 1, 0, 32'h0,          1, 32'h103,        1, 32'h0,          32'h13);
        vecs[17] = mk(1'b0, 1, 0, 32'h0,          0, 32'h100,        0, 32'h100,        W100);
        vecs[18] = mk(1'b0, 1, 0, 32'h0,          1, 32'h104,        1, 32'h100,        W100);
        vecs[19] = mk(1'b0, 1, 0, 32'h0,          1, 32'h105,        1, 32'h100,        W100);
        vecs[20] = mk(1'b0, 1, 0, 32'h0,          1, 32'h106,        1, 32'h100,        W100);
        vecs[21] = mk(1'b0, 1, 1, 32'h200,        1, 32'h107,        1, 32'h100,        W100);   // branch with 4th ack
        vecs[22] = mk(1'b0, 1, 0, 32'h0,          1, 32'h200,        1, 32'h100,        W100);

        rst           = 1'b1;
        stall         = 6'h00;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        ack_en        = 1'b1;
        stall_be      = 6'h01;   // BE instance holds after its first word
        branch_be     = 1'b0;
        target_be     = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            stall         = {5'd0, vecs[i].stall0};
            ack_en        = vecs[i].ack;
            branch_flag   = vecs[i].br;
            branch_target = vecs[i].tgt;
            #1;
            check($sformatf("v%0d req", i),         {31'd0, req_le},  {31'd0, vecs[i].req});
            check($sformatf("v%0d addr", i),        addr_le,          vecs[i].addr);
            check($sformatf("v%0d stallreq", i),    {31'd0, sreq_le}, {31'd0, vecs[i].sreq});
            check($sformatf("v%0d if_pc", i),       pc_le,            vecs[i].pc);
            check($sformatf("v%0d if_inst", i),     inst_le,          vecs[i].inst);
            step();
        end

        // Big-endian instance: bytes 00,00,00,13 at 0x0 form 0x00000013.
        #1;
        check("be if_inst", inst_be, 32'h0000_0013);
        check("be if_pc",   pc_be,   32'h0);
        check("be req held", {31'd0, req_be}, 32'd0);

        // Finish the 0x200 word, then redirect from HOLD to 0xFFFFFFFE (-> ...FC).
        step(); step(); step();
        #1;
        check("w200 req",     {31'd0, req_le}, 32'd0);
        check("w200 if_pc",   pc_le,           32'h200);
        check("w200 if_inst", inst_le,         W100);
        stall         = 6'h01;
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        step();
        branch_flag   = 1'b0;
        stall         = 6'h00;
        #1;
        check("hold br req", {31'd0, req_le}, 32'd0);
        step();
        #1;
        check("wrap fetch req",  {31'd0, req_le}, 32'd1);
        check("wrap fetch addr", addr_le,         32'hFFFF_FFFC);
        repeat (4) step();
        #1;
        check("wrap word if_pc",   pc_le,           32'hFFFF_FFFC);
        check("wrap word if_inst", inst_le,         WWRAP);
        check("wrap word req",     {31'd0, req_le}, 32'd0);
        step();
        #1;
        check("pc+4 wrap req",  {31'd0, req_le}, 32'd1);
        check("pc+4 wrap addr", addr_le,         32'h0);
        step();
        #1;
        check("pre-reset addr", addr_le, 32'h1);
        step();
        rst = 1'b1;                      // reset while fetching byte 2
        step();
        #1;
        check("mid-rst req",     {31'd0, req_le}, 32'd0);
        check("mid-rst if_pc",   pc_le,           32'h0);
        check("mid-rst if_inst", inst_le,         32'h0);
        rst = 1'b0;
        step();
        #1;
        check("restart req",  {31'd0, req_le}, 32'd1);
        check("restart addr", addr_le,         32'h0);
        repeat (4) step();
        #1;
        check("restart if_inst", inst_le,         32'h0000_0013);
        check("restart if_pc",   pc_le,           32'h0);
        check("restart hold",    {31'd0, req_le}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
